// File: rtl/prefetch_queue_pkg.sv
// prefetch_queue_pkg: shared constants, FSM state type and width helpers for the prefetch queue.
package prefetch_queue_pkg;
    localparam int FETCH_BYTES  = 4;
    localparam int WINDOW_BYTES = 16;
    localparam int MAX_INSN_LEN = 15;

    typedef enum logic {STREAM, ALIGN} state_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // one extra bit so a completely full queue is representable
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/prefetch_queue_ram.sv
// prefetch_queue_ram: circular byte store with a 4-byte masked write port and a 16-byte wrapped read window.
// Per-byte fault tags exist only when W80386DX_PREFETCH_FAULT_TAG_EN is defined.
module prefetch_queue_ram
    import prefetch_queue_pkg::*;
#(
    parameter int DEPTH_BYTES = 32,
    parameter int PW          = ptr_width(DEPTH_BYTES)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_ptr,
    input  logic [3:0]    wr_mask,
    input  logic [31:0]   wr_data,
    input  logic          wr_fault,
    input  logic [PW-1:0] rd_ptr,
    output logic [7:0]    rd_data [0:15],
    output logic [15:0]   rd_fault
);
    logic [7:0] mem [DEPTH_BYTES];

    // lanes are pre-packed by the caller, so lane k always lands at wr_ptr+k
    always_ff @(posedge clock) begin
        for (int k = 0; k < FETCH_BYTES; k++)
            if (wr_en && wr_mask[k]) mem[wr_ptr + PW'(k)] <= wr_data[8*k +: 8];
    end

`ifdef W80386DX_PREFETCH_FAULT_TAG_EN
    logic fault_mem [DEPTH_BYTES];

    always_ff @(posedge clock) begin
        for (int k = 0; k < FETCH_BYTES; k++)
            if (wr_en && wr_mask[k]) fault_mem[wr_ptr + PW'(k)] <= wr_fault;
    end
`else
    logic unused_fault;
    assign unused_fault = wr_fault;
`endif

    for (genvar i = 0; i < WINDOW_BYTES; i++) begin : g_rd
        assign rd_data[i] = mem[rd_ptr + PW'(i)];
`ifdef W80386DX_PREFETCH_FAULT_TAG_EN
        assign rd_fault[i] = fault_mem[rd_ptr + PW'(i)];
`else
        assign rd_fault[i] = 1'b0;
`endif
    end
endmodule

// File: rtl/prefetch_queue_aligner.sv
// prefetch_queue_aligner: byte-granular prefetch queue presenting a 16-byte decode window.
// Optional per-byte fault tagging: define W80386DX_PREFETCH_FAULT_TAG_EN.
module prefetch_queue_aligner
    import prefetch_queue_pkg::*;
#(
    parameter int DEPTH_BYTES = 32,
    parameter int FETCH_BYTES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [1:0]  flush_offset,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_data,
    input  logic        fetch_fault,
    output logic [7:0]  instruction [0:15],
    output logic [5:0]  window_count,
    input  logic        consume_valid,
    input  logic [3:0]  consume_length,
    output logic        consume_ack,
    output logic [15:0] fault_in_window
);
    localparam int PW = ptr_width(DEPTH_BYTES);
    localparam int CW = count_width(DEPTH_BYTES);

    state_t        state, state_next;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic [1:0]    discard, discard_next;
    logic          accept;
    logic [2:0]    written;
    logic [3:0]    consumed;
    logic [7:0]    rd_data [0:15];
    logic [15:0]   rd_fault;

    // free space is judged on registered count only; a same-cycle consume is not credited
    assign fetch_ready = ~flush & ((CW'(DEPTH_BYTES) - count) >= CW'(FETCH_BYTES));
    assign accept      = fetch_valid & fetch_ready;
    assign written     = accept ? 3'(FETCH_BYTES) - {1'b0, discard} : 3'd0;

    assign window_count = (count > CW'(WINDOW_BYTES)) ? 6'(WINDOW_BYTES) : 6'(count);
    assign consume_ack  = consume_valid & (consume_length != 4'd0)
                        & (consume_length <= 4'(MAX_INSN_LEN))
                        & ({2'b00, consume_length} <= window_count) & ~flush;
    assign consumed     = consume_ack ? consume_length : 4'd0;
    assign count_next   = count + CW'(written) - CW'(consumed);

    always_comb begin
        state_next   = state;
        discard_next = discard;
        if (flush) begin
            state_next   = ALIGN;
            discard_next = flush_offset;
        end else if (accept) begin
            state_next   = STREAM;
            discard_next = 2'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= STREAM;
            discard <= 2'd0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
            rd_ptr  <= flush ? '0 : rd_ptr + PW'(consumed);
            wr_ptr  <= flush ? '0 : wr_ptr + PW'(written);
            count   <= flush ? '0 : count_next;
        end
    end

    // dropped low bytes are shifted out so surviving bytes start at lane 0
    prefetch_queue_ram #(.DEPTH_BYTES(DEPTH_BYTES), .PW(PW)) u_ram (
        .clock    (clock),
        .wr_en    (accept),
        .wr_ptr   (wr_ptr),
        .wr_mask  (4'hF >> discard),
        .wr_data  (fetch_data >> {discard, 3'b000}),
        .wr_fault (fetch_fault),
        .rd_ptr   (rd_ptr),
        .rd_data  (rd_data),
        .rd_fault (rd_fault)
    );

    for (genvar i = 0; i < WINDOW_BYTES; i++) begin : g_win
        assign instruction[i]     = (6'(i) < window_count) ? rd_data[i] : 8'h00;
        assign fault_in_window[i] = (6'(i) < window_count) & rd_fault[i];
    end
endmodule

// File: doc/prefetch_queue_aligner.md
Name: prefetch_queue_aligner

Overview:
Byte-granular prefetch queue that sits directly upstream of the instruction decode unit.
- Accepts aligned 32-bit code words from the bus/fetch unit into a circular byte buffer.
- Presents a 16-byte window, starting at the current instruction boundary, as the decode unit's instruction[0:15] input.
- Retires a variable number of bytes (1..15) per cycle when decode reports an instruction length.
- Flush on control transfer restarts the queue at an arbitrary byte offset within the first fetched word.

Parameters:
DEPTH_BYTES, 32, queue capacity in bytes; power of two, at least 32.
FETCH_BYTES, 4, bytes per fetch word; fixed at 4 in this revision.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
flush  input  1  discard all queued bytes and restart
flush_offset  input  2  byte offset within the first word written after a flush
fetch_valid  input  1  fetch_data valid
fetch_ready  output  1  queue can accept a word this cycle
fetch_data  input  32  code word, byte 0 in bits [7:0]
fetch_fault  input  1  word carries a fetch fault (used only with the optional feature)
instruction  output  8 x [0:15]  byte window; instruction[0] is the oldest byte
window_count  output  6  number of valid bytes in the window, 0..16
consume_valid  input  1  decode retires consume_length bytes
consume_length  input  4  bytes to retire, 1..15
consume_ack  output  1  retire accepted this cycle
fault_in_window  output  16  per-byte fault tag (optional feature)

Behaviour:
- Reset (asynchronous): rd_ptr=0, wr_ptr=0, count=0, state=STREAM, discard=0. Outputs: fetch_ready=1, window_count=0, consume_ack=0, instruction all 8'h00, fault_in_window=0.
- State machine:
  - STREAM: normal operation.
  - ALIGN: entered on flush; the next accepted word drops its low flush_offset bytes, then the block returns to STREAM.
  - If flush_offset=0, ALIGN still drops 0 bytes and returns to STREAM.
- Write path:
  - fetch_ready = (DEPTH_BYTES - count) >= 4, evaluated on registered count. A same-cycle consume is not credited.
  - A word is accepted when fetch_valid & fetch_ready. Bytes written = 4 - discard.
  - Written bytes are visible on instruction/window_count the following cycle (1-cycle latency).
- Window:
  - Combinational read of 16 bytes starting at rd_ptr, wrapping modulo DEPTH_BYTES.
  - window_count = min(count, 16).
  - Bytes at positions >= window_count read as 8'h00.
- Consume path:
  - consume_ack = consume_valid & (consume_length != 0) & (consume_length <= window_count) & ~flush. Combinational, same cycle.
  - On ack: rd_ptr += consume_length, modulo DEPTH_BYTES.
  - consume_length=0, or a length greater than window_count, gives no ack and no state change; decode holds and retries.
- Simultaneous write and consume: count_next = count + written - consumed. Both pointers wrap independently.
- Flush has highest priority:
  - rd_ptr=wr_ptr=0, count=0, discard=flush_offset, state=ALIGN.
  - Any same-cycle fetch word is dropped: fetch_ready is forced to 0 while flush=1.
  - Any same-cycle consume is not acked.
- Reset asserted mid-operation clears everything immediately. No partial word survives.
- Overflow is impossible by construction. count never exceeds DEPTH_BYTES.

Optional Feature:
Macro: W80386DX_PREFETCH_FAULT_TAG_EN
- Defined:
  - Each byte stores a fault bit copied from fetch_fault of its word.
  - fault_in_window[i] is set for window byte i when i < window_count.
  - A faulted word is still queued, so decode raises the fault only if it reaches those bytes.
- Undefined:
  - fetch_fault is ignored.
  - fault_in_window is tied to 0.
  - No tag storage is synthesized.

Decomposition:
- Package prefetch_queue_pkg: FETCH_BYTES, WINDOW_BYTES=16, MAX_INSN_LEN=15, the state enum {STREAM, ALIGN}, and pointer/count width functions derived from DEPTH_BYTES.
- Sub-module prefetch_queue_ram: byte array plus optional tag bits, with a 4-byte wrapped write port and a 16-byte wrapped read window.
- The top level holds pointers, count, the FSM and the handshakes.

Test Plan:
- Fill then drain: after reset, write 0x03020100 and 0x07060504; the next cycle shows window_count=8 and instruction[0..7]=00..07. Consume 3 -> ack, then instruction[0]=03 and window_count=5.
- Aligned flush: flush with flush_offset=2, then write 0xDDCCBBAA -> window_count=2, instruction[0]=CC, instruction[1]=DD.
- Full and wrap: write 8 words (32 bytes) -> fetch_ready=0. Consume 15 -> the next cycle fetch_ready=1. Keep writing across the wrap; the window stays byte-exact at rd_ptr 30..31..0.
- Short window: with window_count=5, consume_length=6 -> consume_ack=0 and no change. consume_length=0 -> consume_ack=0.
- Simultaneous: count=8, write a word and consume 4 in the same cycle -> count=8, correct bytes. flush+write+consume in one cycle -> count=0, no ack, word dropped.
- Fault tag (macro defined): write a word with fetch_fault=1 after 4 clean bytes -> fault_in_window=16'h00F0.
